// File: rtl/board_io_bridge.sv
// board_io_bridge: board-side endpoint of the core's memory-mapped I/O buses.
// Raw pushbuttons and slide switches are synchronised and debounced into
// io_input_bus. The core's io_output_bus is registered onto the six
// seven-segment displays and the ten LEDs.
module board_io_bridge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit HEX_ACTIVE_LOW  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  output logic [13:0] io_input_bus,
  input  logic [51:0] io_output_bus,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [9:0]  ledr
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [6:0]    HEX_MASK = HEX_ACTIVE_LOW ? 7'h7F : 7'h00;

  // Buttons are inverted at the pin so that 1 means pressed everywhere downstream.
  logic [13:0] pin_level;
  assign pin_level = {~key_n, sw};

  logic [13:0]   sync_s1;
  logic [13:0]   sync_s2;
  logic [13:0]   stable;
  logic [CW-1:0] count [14];
  logic [51:0]   out_q;

  // Two-flop synchroniser bringing the asynchronous pins into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= pin_level;
      sync_s2 <= sync_s1;
    end
  end

  // Per-channel debounce: accept a new level only after it has differed from
  // the accepted level for DEBOUNCE_CYCLES consecutive cycles. Any return to
  // the accepted level clears the count, so the counter can never wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 14; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (sync_s2[i] == stable[i]) begin
          count[i] <= '0;
        end else if (count[i] == CNT_LAST) begin
          stable[i] <= sync_s2[i];
          count[i]  <= '0;
        end else begin
          count[i] <= count[i] + CNT_ONE;
        end
      end
    end
  end

  // Output register so no pin is ever driven combinationally by the core.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= io_output_bus;
    end
  end

  assign io_input_bus = stable;

  assign ledr = out_q[9:0];
  assign hex0 = out_q[16:10] ^ HEX_MASK;
  assign hex1 = out_q[23:17] ^ HEX_MASK;
  assign hex2 = out_q[30:24] ^ HEX_MASK;
  assign hex3 = out_q[37:31] ^ HEX_MASK;
  assign hex4 = out_q[44:38] ^ HEX_MASK;
  assign hex5 = out_q[51:45] ^ HEX_MASK;

endmodule

// File: tb/tb_board_io_bridge.sv
// tb_board_io_bridge: scoreboard bench for board_io_bridge with a short
// debounce window. Expected values are queued against an edge number when
// stimulus is driven and compared by a monitor just after that edge.
module tb_board_io_bridge;

  localparam int DB = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic [13:0] io_input_bus;
  logic [51:0] io_output_bus;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [9:0]  ledr;

  typedef struct {
    int          at_edge;
    int          kind;
    logic [13:0] val;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt;
  int   total;
  int   bad;

  board_io_bridge #(
    .DEBOUNCE_CYCLES(DB),
    .HEX_ACTIVE_LOW (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key_n        (key_n),
    .sw           (sw),
    .io_input_bus (io_input_bus),
    .io_output_bus(io_output_bus),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3),
    .hex4         (hex4),
    .hex5         (hex5),
    .ledr         (ledr)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point; counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int at, input logic [13:0] got,
                             input logic [13:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at edge %0d: got %h expected %h", tag, at, got, want);
    end
  endtask

  function automatic logic [13:0] observe(input int kind);
    case (kind)
      0:       return io_input_bus;
      1:       return {4'h0, ledr};
      2:       return {7'h0, hex0};
      3:       return {7'h0, hex1};
      4:       return {7'h0, hex2};
      5:       return {7'h0, hex3};
      6:       return {7'h0, hex4};
      default: return {7'h0, hex5};
    endcase
  endfunction

  function automatic string kind_name(input int kind);
    case (kind)
      0:       return "io_input_bus";
      1:       return "ledr";
      2:       return "hex0";
      3:       return "hex1";
      4:       return "hex2";
      5:       return "hex3";
      6:       return "hex4";
      default: return "hex5";
    endcase
  endfunction

  task automatic push_exp(input int at, input int kind, input logic [13:0] val);
    exp_t e;
    e.at_edge = at;
    e.kind    = kind;
    e.val     = val;
    sb.push_back(e);
  endtask

  task automatic expect_in(input int at, input logic [13:0] val);
    push_exp(at, 0, val);
  endtask

  // Expected display outputs for a bus value captured at the given edge.
  task automatic expect_out(input int at, input logic [51:0] bus);
    push_exp(at, 1, {4'h0, bus[9:0]});
    push_exp(at, 2, {7'h0, ~bus[16:10]});
    push_exp(at, 3, {7'h0, ~bus[23:17]});
    push_exp(at, 4, {7'h0, ~bus[30:24]});
    push_exp(at, 5, {7'h0, ~bus[37:31]});
    push_exp(at, 6, {7'h0, ~bus[44:38]});
    push_exp(at, 7, {7'h0, ~bus[51:45]});
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] k, input logic [9:0] s,
                               input logic [51:0] ob);
    reset         = rst;
    key_n         = k;
    sw            = s;
    io_output_bus = ob;
  endtask

  task automatic advance(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: numbers each rising edge and checks everything due at it.
  initial begin
    exp_t e;
    edge_cnt = 0;
    forever begin
      @(posedge clock);
      #1;
      edge_cnt++;
      while (sb.size() > 0 && sb[0].at_edge <= edge_cnt) begin
        e = sb.pop_front();
        checkOutput(kind_name(e.kind), e.at_edge, observe(e.kind), e.val);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    logic [51:0] ob;
    int          wait_cycles;
    total = 0;
    bad   = 0;

    // Reset values, with busy inputs that must not get through.
    applyStimulus(1'b0, 4'h0, 10'h3FF, 52'hA_BCDE_F012_3456);
    for (int t = 1; t <= 2; t++) begin
      expect_in(t, 14'h0000);
      push_exp(t, 1, 14'h0000);
      for (int h = 2; h <= 7; h++) push_exp(t, h, 14'h007F);
    end
    advance(2);

    // Clean press of KEY0: appears exactly at the sixth edge, nothing else moves.
    base = edge_cnt;
    applyStimulus(1'b1, 4'b1110, 10'h000, 52'h0);
    for (int t = 1; t <= 5; t++) expect_in(base + t, 14'h0000);
    expect_in(base + 6, 14'h0400);
    advance(6);

    // Bounce on SW3 rejected, then a held change accepted after full latency.
    base = edge_cnt;
    for (int t = 1; t <= 11; t++) expect_in(base + t, 14'h0400);
    expect_in(base + 12, 14'h0408);
    applyStimulus(1'b1, 4'b1110, 10'h008, 52'h0);
    advance(3);
    applyStimulus(1'b1, 4'b1110, 10'h000, 52'h0);
    advance(3);
    applyStimulus(1'b1, 4'b1110, 10'h008, 52'h0);
    advance(6);

    // Reset mid-debounce of SW9; held inputs re-debounce from release.
    base = edge_cnt;
    ob   = 52'hF_0F0F_0F0F_03FF;
    for (int t = 1; t <= 3; t++) begin
      expect_in(base + t, 14'h0408);
      expect_out(base + t, ob);
    end
    expect_in(base + 4, 14'h0000);
    expect_out(base + 4, 52'h0);
    for (int t = 5; t <= 9; t++) begin
      expect_in(base + t, 14'h0000);
      expect_out(base + t, ob);
    end
    expect_in(base + 10, 14'h0608);
    applyStimulus(1'b1, 4'b1110, 10'h208, ob);
    advance(3);
    applyStimulus(1'b0, 4'b1110, 10'h208, ob);
    advance(1);
    applyStimulus(1'b1, 4'b1110, 10'h208, ob);
    advance(6);

    // Output mapping with one-cycle latency.
    base = edge_cnt;
    applyStimulus(1'b1, 4'b1110, 10'h208, 52'h0_0000_0000_F7FF);
    push_exp(base + 1, 1, 14'h03FF);
    push_exp(base + 1, 2, 14'h0042);
    for (int h = 3; h <= 7; h++) push_exp(base + 1, h, 14'h007F);
    advance(1);
    applyStimulus(1'b1, 4'b1110, 10'h208, 52'hF_E000_0000_0000);
    push_exp(base + 2, 1, 14'h0000);
    for (int h = 2; h <= 6; h++) push_exp(base + 2, h, 14'h007F);
    push_exp(base + 2, 7, 14'h0000);
    advance(1);
    for (int t = 3; t <= 6; t++) begin
      ob = {$urandom(), $urandom()};
      applyStimulus(1'b1, 4'b1110, 10'h208, ob);
      expect_out(base + t, ob);
      advance(1);
    end

    // Concurrent changes on many channels land together with no partial value.
    base = edge_cnt;
    applyStimulus(1'b1, 4'h0, 10'h2AA, 52'h0);
    for (int t = 1; t <= 5; t++) expect_in(base + t, 14'h0608);
    expect_in(base + 6, 14'h3EAA);
    expect_in(base + 7, 14'h3EAA);
    advance(7);

    // Drain anything still pending, bounded.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      advance(1);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
